param_adding_machine: RTL and testbench

//  Parametrised successor of the single-ROM adding machine: sums a programmable block of memory words.
//  One run covers COUNT words starting at BASE, through a PIPE-deep fetch pipeline.
//  Per-run mode selects add/sub/xor/signed-max.
//  The block is a stand-alone accumulator engine in the lab datapath, driving a combinational memory read port.

---
 rtl/pam_pkg.sv | 18 +
 rtl/pam_alu.sv | 56 +++++
 rtl/param_adding_machine.sv | 138 +++++++++++++
 tb/tb_param_adding_machine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pam_pkg.sv
// Shared encodings for the parametrised adding machine.
// Mode and FSM state values used by the top and the ALU.
package pam_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_XOR = 2'b10,
        MODE_MAX = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pam_alu.sv
// Combinational accumulate step f(acc, d, mode) with signed overflow flag.
// SATURATE_EN: ADD/SUB clamp to signed max/min on overflow.
module pam_alu
    import pam_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] d,
    input  mode_e            mode,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic             add_ov;
    logic             sub_ov;

    assign sum = acc + d;
    assign dif = acc - d;

    // Overflow iff the result sign disagrees with what the operand signs allow.
    assign add_ov = (acc[WIDTH-1] == d[WIDTH-1]) &&
                    (sum[WIDTH-1] != acc[WIDTH-1]);
    assign sub_ov = (acc[WIDTH-1] != d[WIDTH-1]) &&
                    (dif[WIDTH-1] != acc[WIDTH-1]);

    always_comb begin
        res = acc;
        ovf = 1'b0;
        unique case (mode)
            MODE_ADD: begin
                res = sum;
                ovf = add_ov;
            end
            MODE_SUB: begin
                res = dif;
                ovf = sub_ov;
            end
            MODE_XOR: res = acc ^ d;
            MODE_MAX: res = ($signed(d) > $signed(acc)) ? d : acc;
            default:  res = acc;
        endcase
`ifdef SATURATE_EN
        // Overflow direction always follows the sign of acc.
        if (ovf) res = acc[WIDTH-1] ? SMIN : SMAX;
`else
        res = res;
`endif
    end

endmodule

// File: rtl/param_adding_machine.sv
// Accumulates COUNT memory words from BASE through a PIPE-deep fetch pipe.
// SATURATE_EN (in pam_alu) selects clamping ADD/SUB instead of wrapping.
module param_adding_machine
    import pam_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 30,
    parameter int PIPE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam logic [PIPE-1:0] LAST_ONLY = PIPE'(1) << (PIPE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    mode_e             mode_q, mode_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [PIPE-1:0]   vld_q, vld_d;
    logic [WIDTH-1:0]  pdat_q [PIPE];
    logic [WIDTH-1:0]  pdat_d [PIPE];

    logic              accept;
    logic              issue;
    logic              drained;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_ovf;

    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start && count != '0) state_d = S_RUN;
            S_RUN:   if (rem_q == ADDR_W'(1)) state_d = S_DRAIN;
            S_DRAIN: if (drained) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Tokens are contiguous in DRAIN, so only the last stage holding
    // one means the final word is being accumulated this cycle.
    always_comb begin
        busy    = (state_q != S_IDLE);
        issue   = (state_q == S_RUN);
        drained = (state_q == S_DRAIN) && (vld_q == LAST_ONLY);
        done_d  = (accept && count == '0) || drained;
    end

    always_comb begin
        vld_d[0]  = issue;
        pdat_d[0] = issue ? mem_data : pdat_q[0];
        for (int i = 1; i < PIPE; i++) begin
            vld_d[i]  = vld_q[i-1];
            pdat_d[i] = pdat_q[i-1];
        end
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (issue) begin
            rem_d = rem_q - ADDR_W'(1);
            if (rem_q != ADDR_W'(1)) addr_d = addr_q + ADDR_W'(1);
        end
        if (vld_q[PIPE-1]) begin
            acc_d = alu_res;
            ovf_d = ovf_q | alu_ovf;
        end
        if (accept) begin
            mode_d = mode_e'(mode);
            rem_d  = count;
            acc_d  = '0;
            ovf_d  = 1'b0;
            if (count != '0) addr_d = base;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            rem_q  <= '0;
            mode_q <= MODE_ADD;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            vld_q  <= '0;
            for (int i = 0; i < PIPE; i++) pdat_q[i] <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            mode_q <= mode_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            vld_q  <= vld_d;
            for (int i = 0; i < PIPE; i++) pdat_q[i] <= pdat_d[i];
        end
    end

    pam_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .acc (acc_q),
        .d   (pdat_q[PIPE-1]),
        .mode(mode_q),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    assign mem_addr = addr_q;
    assign out      = acc_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_adding_machine.sv
// Directed bench for param_adding_machine: PIPE=1 and PIPE=3 side by side.
// Honours SATURATE_EN when it is defined for the build.
module tb_param_adding_machine;
    import pam_pkg::*;

    localparam int AW = 30;
    localparam int W  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    logic [1:0]    mode;
    logic [AW-1:0] addr  [2];
    logic [W-1:0]  rdata [2];
    logic [W-1:0]  outv  [2];
    logic          busy  [2];
    logic          done  [2];
    logic          ovf   [2];
    logic [W-1:0]  mem   [16];

    int checks = 0;
    int errors = 0;

    assign rdata[0] = mem[addr[0][3:0]];
    assign rdata[1] = mem[addr[1][3:0]];

    param_adding_machine #(.WIDTH(W), .ADDR_W(AW), .PIPE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .base(base),
        .count(count), .mode(mode), .mem_addr(addr[0]),
        .mem_data(rdata[0]), .out(outv[0]), .busy(busy[0]),
        .done(done[0]), .ovf(ovf[0])
    );

    param_adding_machine #(.WIDTH(W), .ADDR_W(AW), .PIPE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .base(base),
        .count(count), .mode(mode), .mem_addr(addr[1]),
        .mem_data(rdata[1]), .out(outv[1]), .busy(busy[1]),
        .done(done[1]), .ovf(ovf[1])
    );

    typedef struct packed {
        logic [AW-1:0]     base;
        logic [AW-1:0]     cnt;
        logic [1:0]        mode;
        logic [3:0][W-1:0] d;
        logic [W-1:0]      exp_out;
        logic              exp_ovf;
    } vec_t;

    vec_t vt [10];

    function automatic vec_t mk(input logic [AW-1:0] b, input logic [AW-1:0] n,
                                input logic [1:0] m,
                                input logic [W-1:0] d0, input logic [W-1:0] d1,
                                input logic [W-1:0] d2, input logic [W-1:0] d3,
                                input logic [W-1:0] eo, input logic ev);
        vec_t v;
        v.base    = b;
        v.cnt     = n;
        v.mode    = m;
        v.d       = {d3, d2, d1, d0};
        v.exp_out = eo;
        v.exp_ovf = ev;
        return v;
    endfunction

    function automatic int pipe_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s p%0d out", nm, pipe_of(k)), outv[k], '0);
            chk($sformatf("%s p%0d addr", nm, pipe_of(k)), W'(addr[k]), '0);
            chk($sformatf("%s p%0d busy", nm, pipe_of(k)), W'(busy[k]), '0);
            chk($sformatf("%s p%0d done", nm, pipe_of(k)), W'(done[k]), '0);
            chk($sformatf("%s p%0d ovf", nm, pipe_of(k)), W'(ovf[k]), '0);
        end
    endtask

    task automatic run(input int id, input vec_t v);
        int done_c [2];
        int done_n [2];
        int busy_n [2];
        int lim;
        int p;
        int en;
        logic [AW-1:0] ea;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
        for (int i = 0; i < 4; i++)
            if (i < int'(v.cnt)) mem[4'(v.base + AW'(i))] = v.d[i];
        for (int k = 0; k < 2; k++) begin
            done_c[k] = 0;
            done_n[k] = 0;
            busy_n[k] = 0;
        end
        @(negedge clk);
        base  = v.base;
        count = v.cnt;
        mode  = v.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base  = AW'($urandom);
        count = AW'($urandom);
        mode  = 2'($urandom);
        lim   = int'(v.cnt) + 7;
        for (int c = 1; c <= lim; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (busy[k]) busy_n[k]++;
                if (done[k]) begin
                    done_n[k]++;
                    if (done_c[k] == 0) done_c[k] = c;
                end
                if (c <= int'(v.cnt)) begin
                    ea = v.base + AW'(c - 1);
                    chk($sformatf("v%0d p%0d addr c%0d", id, pipe_of(k), c),
                        W'(addr[k]), W'(ea));
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            p  = pipe_of(k);
            en = (v.cnt == '0) ? 0 : 1;
            chk($sformatf("v%0d p%0d out", id, p), outv[k], v.exp_out);
            chk($sformatf("v%0d p%0d ovf", id, p), W'(ovf[k]), W'(v.exp_ovf));
            chk($sformatf("v%0d p%0d done_cycle", id, p), W'(done_c[k]),
                W'(en * (int'(v.cnt) + p) + 1));
            chk($sformatf("v%0d p%0d busy_cycles", id, p), W'(busy_n[k]),
                W'(en * (int'(v.cnt) + p)));
            chk($sformatf("v%0d p%0d done_pulses", id, p), W'(done_n[k]), 1);
        end
    endtask

    initial begin
        int dn;
        vt[0] = mk(30'h0, 4, MODE_ADD, 1, 2, 3, 4, 32'd10, 1'b0);
        vt[1] = mk(30'h3FFF_FFFE, 4, MODE_ADD, 1, 1, 1, 1, 32'd4, 1'b0);
        vt[2] = mk(30'h7, 0, MODE_ADD, 9, 9, 9, 9, 32'd0, 1'b0);
`ifdef SATURATE_EN
        vt[3] = mk(30'h3, 2, MODE_ADD, 32'h7FFF_FFFF, 1, 0, 0,
                   32'h7FFF_FFFF, 1'b1);
        vt[7] = mk(30'h5, 1, MODE_SUB, 32'h8000_0000, 0, 0, 0,
                   32'h7FFF_FFFF, 1'b1);
        vt[8] = mk(30'h3FFF_FFFF, 3, MODE_ADD, 32'h7FFF_FFFF, 1, 1, 0,
                   32'h7FFF_FFFF, 1'b1);
        vt[9] = mk(30'h2, 2, MODE_SUB, 2, 32'h7FFF_FFFF, 0, 0,
                   32'h8000_0000, 1'b1);
`else
        vt[3] = mk(30'h3, 2, MODE_ADD, 32'h7FFF_FFFF, 1, 0, 0,
                   32'h8000_0000, 1'b1);
        vt[7] = mk(30'h5, 1, MODE_SUB, 32'h8000_0000, 0, 0, 0,
                   32'h8000_0000, 1'b1);
        vt[8] = mk(30'h3FFF_FFFF, 3, MODE_ADD, 32'h7FFF_FFFF, 1, 1, 0,
                   32'h8000_0001, 1'b1);
        vt[9] = mk(30'h2, 2, MODE_SUB, 2, 32'h7FFF_FFFF, 0, 0,
                   32'h7FFF_FFFF, 1'b1);
`endif
        vt[4] = mk(30'h9, 3, MODE_MAX, 32'hFFFF_FFFB, 3, 32'hFFFF_FFFF, 0,
                   32'd3, 1'b0);
        vt[5] = mk(30'h4, 2, MODE_SUB, 1, 2, 0, 0, 32'hFFFF_FFFD, 1'b0);
        vt[6] = mk(30'hC, 3, MODE_XOR, 32'hF0F0, 32'h0FF0, 1, 0,
                   32'hFF01, 1'b0);

        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        count = '0;
        mode  = 2'b00;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #2 reset = 1'b0;
        #1 chk_idle("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run(i, vt[i]);

        // Abort: second start mid-run ignored, then reset in cycle 5.
        for (int i = 0; i < 16; i++) mem[i] = 32'd1;
        @(negedge clk);
        base  = '0;
        count = 30'd8;
        mode  = MODE_ADD;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        base  = 30'd5;
        count = 30'd2;
        mode  = MODE_XOR;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++)
            chk($sformatf("abort p%0d busy c4", pipe_of(k)), W'(busy[k]), 1);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_idle("abort");
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) if (done[k] || busy[k]) dn++;
        end
        chk("abort no done/busy", W'(dn), 0);

        run(10, vt[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
